muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage. Takes two

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/muldiv_iter_core.sv | 81 ++++++++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
//   muldiv_op_t    : funct3 encoding of the eight M-extension operations
//   muldiv_state_t : sequencing states of the unit
//   muldiv_cnt_w() : width of an iteration counter that can hold 'width'
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_WIDTH = 32;

  function automatic int muldiv_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int MULDIV_CNT_W = muldiv_cnt_w(MULDIV_WIDTH);

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring
// shift-subtract divide, one bit per step, over a shared 2*WIDTH register.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture opa/opb/is_div and arm the iteration counter
//   step       : perform one iteration (ignored once the counter is spent)
//   is_div     : 1 = divide, 0 = multiply
//   opa, opb   : unsigned magnitudes (multiplier/multiplicand or dividend/divisor)
//   acc        : multiply -> full product; divide -> {remainder, quotient}
//   last       : the step being taken this cycle is the final one
module muldiv_iter_core
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CNT_W = muldiv_cnt_w(WIDTH);

  logic [WIDTH-1:0] opb_r;
  logic             div_r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0] addend;
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: the low half starts as the multiplier and is shifted out LSB
  // first while partial sums accumulate into the high half.
  // Divide: the high half is the partial remainder, the low half shifts the
  // dividend out MSB first and the quotient bits in LSB first.
  always_comb begin
    // NOTE: every combinational output gets a value on every path (here
    // unconditionally) so no latch is inferred.
    addend  = acc[0] ? {1'b0, opb_r} : '0;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // Partial remainder is always below the divisor, so a borrow shows up
    // as bit WIDTH of the difference.
    diff    = shifted - {1'b0, opb_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath is a handful of flops, not a memory, so it is
      // cleared with everything else and never holds stale operands.
      acc   <= '0;
      opb_r <= '0;
      div_r <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, opa};
      opb_r <= opb;
      div_r <= is_div;
      cnt   <= CNT_W'(WIDTH);
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
      if (div_r) begin
        if (diff[WIDTH]) begin
          acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
          acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc <= {add_sum, acc[WIDTH-1:1]};
      end
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Sequencing IDLE -> CALC (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE;
// divide-by-zero and signed-overflow divides go IDLE -> DONE directly.
//   clk, reset : clock and synchronous active-high reset
//   start      : request, honoured only while ready
//   op         : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b       : rs1 / rs2 operands, captured at the accepting edge
//   ready      : unit idle, can accept start
//   busy       : iterating or applying the sign fix-up
//   done       : one-cycle pulse, result valid
//   result     : last result, held until the next done
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t state, state_next;
  muldiv_op_t    op_in, op_r;

  logic             accept;
  logic             is_div_in;
  logic             a_signed, b_signed;
  logic             sign_a, sign_b;
  logic             div_by_zero, div_overflow, special;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] special_result;

  // neg_res_r: product/quotient must be negated; neg_rem_r: remainder must be
  logic             neg_res_r, neg_rem_r;

  logic [2*WIDTH-1:0] core_acc;
  logic               core_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   fix_result;

  assign op_in  = muldiv_op_t'(op);
  assign ready  = (state == IDLE);
  assign busy   = (state == CALC) || (state == FIX);
  assign accept = ready && start;

  // Operand decode for the request being offered this cycle.
  always_comb begin
    is_div_in      = op[2];
    a_signed       = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                     (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed       = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sign_a         = a_signed && a[WIDTH-1];
    sign_b         = b_signed && b[WIDTH-1];
    mag_a          = sign_a ? -a : a;
    mag_b          = sign_b ? -b : b;
    div_by_zero    = is_div_in && (b == '0);
    div_overflow   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (a == MIN_NEG) && (b == '1);
    special        = div_by_zero || div_overflow;
    special_result = '0;
    if (div_by_zero) begin
      // op[1] distinguishes REM/REMU (6,7) from DIV/DIVU (4,5)
      special_result = op[1] ? a : '1;
    end else if (div_overflow) begin
      special_result = (op_in == OP_DIV) ? a : '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = special ? DONE : CALC;
      CALC: if (core_last) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && !special),
    .step   (state == CALC),
    .is_div (is_div_in),
    .opa    (mag_a),
    .opb    (mag_b),
    .acc    (core_acc),
    .last   (core_last)
  );

  // Sign fix-up and result select, consumed while in FIX.
  always_comb begin
    prod_fix   = neg_res_r ? -core_acc : core_acc;
    quot       = core_acc[WIDTH-1:0];
    rem        = core_acc[2*WIDTH-1:WIDTH];
    fix_result = '0;
    unique case (op_r)
      OP_MUL:                       fix_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_result = neg_res_r ? -quot : quot;
      OP_REM, OP_REMU:              fix_result = neg_rem_r ? -rem : rem;
      default:                      fix_result = '0;
    endcase
  end

  // Captured request attributes, done pulse and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= OP_MUL;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= (state_next == DONE);
      if (accept) begin
        op_r      <= op_in;
        neg_res_r <= sign_a ^ sign_b;
        neg_rem_r <= sign_a;
        if (special) begin
          result <= special_result;
        end
      end
      if (state == FIX) begin
        result <= fix_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed vector table,
// hand-written multi-cycle sequences (ignored starts, mid-operation reset)
// and randomized operations checked against a plain-arithmetic reference.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, uy, p;
    logic [63:0] pu;
    logic [31:0] r;
    logic        ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    uy  = longint'({32'h0, y});
    pu  = {32'h0, x} * {32'h0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r   = '0;
    case (o)
      3'd0: r = pu[31:0];
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (ovf) r = 32'h0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o[2] && (y == 0)) return 1;
    if (((o == 3'd4) || (o == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF))
      return 1;
    return 34;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready before issue"}, 32'(ready), 32'd1);
  endtask

  // Issue one operation and check latency, handshake and result.
  // Cycle 1 is the period following the accepting edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int   cyc;
    logic ready_leak;
    logic busy1;
    wait_ready(tag);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    busy1      = busy;
    ready_leak = 1'b0;
    cyc        = 1;
    while (!done && cyc < 100) begin
      ready_leak |= ready;
      @(negedge clk);
      cyc++;
    end
    ready_leak |= ready;
    check({tag, " done cycle"}, 32'(cyc), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " ready low until done"}, 32'(ready_leak), 32'd0);
    check({tag, " busy in cycle 1"}, 32'(busy1), 32'(exp_lat != 1));
  endtask

  vec_t vecs[14];

  initial begin
    int          n_done;
    int          done_cyc;
    logic [31:0] held;
    logic        hold_bad;
    logic        seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 34};
    vecs[7]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[11] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[12] = '{3'd0, 32'h1234_5678, 32'd0,         32'd0,         34};
    vecs[13] = '{3'd7, 32'd100,        32'd7,         32'd2,         34};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Starts during CALC are ignored; result then held with start low.
    wait_ready("ignored starts");
    start = 1'b1; op = 3'd4; a = 32'hFFFF_FF9C; b = 32'd7;
    @(posedge clk);
    n_done = 0; done_cyc = 0; held = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
        held = result;
      end
      start = (cyc == 3) || (cyc == 20);
      op = 3'd4; a = 32'd1; b = 32'd0;
    end
    check("ignored starts done count", 32'(n_done), 32'd1);
    check("ignored starts done cycle", 32'(done_cyc), 32'd34);
    check("ignored starts result", held, 32'hFFFF_FFF2);
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result !== 32'hFFFF_FFF2 || done !== 1'b0) hold_bad = 1'b1;
    end
    check("result held 10 cycles", 32'(hold_bad), 32'd0);

    // Reset in the middle of a multiply abandons it.
    wait_ready("mid reset");
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset ready", 32'(ready), 32'd1);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset result", result, 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen |= done;
    end
    check("no done after reset", 32'(seen), 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu after reset");

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, ref_result(ro, ra, rb), ref_latency(ro, ra, rb),
             $sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
